// File: rtl/brew_sched_pkg.sv
// Shared definitions for the brew scheduler: FSM state codes, default
// phase lengths and a small index-to-one-hot helper.
package brew_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CUP   = 3'd1,
    ST_POUR  = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam int CUP_CYC_DEF  = 4;
  localparam int POUR_CYC_DEF = 8;
  localparam int CNT_W_DEF    = 8;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/brew_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, purely combinational.
//   cand[1:0]  in   requesters competing this cycle
//   last       in   index of the requester served most recently
//   win[1:0]   out  one-hot winner, 00 when no candidate
module rr_arb2 (
  input  logic [1:0] cand,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    case (cand)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      // On a tie the requester not served last time wins.
      2'b11:   win = last ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/brew_sched.sv
// brew_sched: shares one brewing unit between two vending front-ends.
// Sale pulses are queued (depth 1 per front-end), arbitrated round-robin
// and served with a timed cup-drop / cup-check / pour sequence.
//   CLK       in   system clock, rising edge
//   RST       in   synchronous reset, active-high
//   req[1:0]  in   1-cycle sale pulse per front-end
//   cup_ok    in   cup-present sensor, looked at on the last CUP cycle
//   busy      out  sequence in progress (CUP/POUR/DONE/FAULT)
//   gnt[1:0]  out  one-hot owner for the whole sequence
//   cup_drop  out  cup dropper drive
//   pour      out  pour valve drive
//   done[1:0] out  1-cycle completion pulse to the owner
//   refund[1:0] out 1-cycle refund pulse to the owner on missing cup
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | waiting; arbitrates pending | req
// ST_CUP   | cup_drop held for CUP_CYC cycles
// ST_POUR  | pour held for POUR_CYC cycles
// ST_DONE  | done pulse to owner, then back to idle
// ST_FAULT | refund pulse to owner, then back to idle
module brew_sched
  import brew_sched_pkg::*;
#(
  parameter int CUP_CYC  = CUP_CYC_DEF,
  parameter int POUR_CYC = POUR_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       cup_ok,
  output logic       busy,
  output logic [1:0] gnt,
  output logic       cup_drop,
  output logic       pour,
  output logic [1:0] done,
  output logic [1:0] refund
);

  localparam logic [CNT_W-1:0] CUP_LD  = CNT_W'(CUP_CYC - 1);
  localparam logic [CNT_W-1:0] POUR_LD = CNT_W'(POUR_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       pending, pending_nxt;
  logic             last, last_nxt;
  logic             owner, owner_nxt;
  logic [1:0]       cand, win;

  assign cand = pending | req;

  rr_arb2 u_arb (
    .cand (cand),
    .last (last),
    .win  (win)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pending <= 2'b00;
      last    <= 1'b1;
      owner   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
      last    <= last_nxt;
      owner   <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    owner_nxt   = owner;
    last_nxt    = last;
    // Requests are captured in every state; a repeat while already
    // pending simply ORs into the same bit and is lost.
    pending_nxt = pending | req;
    case (state)
      ST_IDLE: begin
        if (cand != 2'b00) begin
          state_nxt   = ST_CUP;
          owner_nxt   = win[1];
          cnt_nxt     = CUP_LD;
          pending_nxt = cand & ~win;
        end
      end
      ST_CUP: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else if (cup_ok) begin
          state_nxt = ST_POUR;
          cnt_nxt   = POUR_LD;
        end else begin
          state_nxt = ST_FAULT;
        end
      end
      ST_POUR: begin
        if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
        else           state_nxt = ST_DONE;
      end
      ST_DONE, ST_FAULT: begin
        last_nxt  = owner;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    gnt      = 2'b00;
    cup_drop = 1'b0;
    pour     = 1'b0;
    done     = 2'b00;
    refund   = 2'b00;
    case (state)
      ST_CUP: begin
        busy     = 1'b1;
        gnt      = onehot2(owner);
        cup_drop = 1'b1;
      end
      ST_POUR: begin
        busy = 1'b1;
        gnt  = onehot2(owner);
        pour = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        gnt  = onehot2(owner);
        done = onehot2(owner);
      end
      ST_FAULT: begin
        busy   = 1'b1;
        gnt    = onehot2(owner);
        refund = onehot2(owner);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_brew_sched.sv
// Testbench for brew_sched with CUP_CYC=4, POUR_CYC=8. Expected done/refund
// events (value and cycle) are queued as stimulus is applied and checked by
// a monitor as the DUT raises them.
module tb_brew_sched;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] req = 2'b00;
  logic       cup_ok = 1'b1;
  logic       busy, cup_drop, pour;
  logic [1:0] gnt, done, refund;

  typedef struct {
    logic [1:0] done;
    logic [1:0] refund;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  brew_sched #(.CUP_CYC(4), .POUR_CYC(8), .CNT_W(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .req      (req),
    .cup_ok   (cup_ok),
    .busy     (busy),
    .gnt      (gnt),
    .cup_drop (cup_drop),
    .pour     (pour),
    .done     (done),
    .refund   (refund)
  );

  initial forever #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_req(input logic [1:0] v);
    req = v;
    tick();
    req = 2'b00;
  endtask

  task automatic expect_ev(input logic [1:0] d, input logic [1:0] r, input int c);
    q.push_back(exp_t'{done: d, refund: r, cyc: c});
  endtask

  task automatic wait_drain(input int bound, input string name);
    int n = 0;
    while (q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_timeout: %0d events outstanding, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLK);
      vectors++;
      if ((cup_drop && pour) || ((|done) && (|refund))) begin
        miscompares++;
        $display("FAIL exclusive: cup_drop=%b pour=%b done=%b refund=%b at cycle %0d, required mutually exclusive",
                 cup_drop, pour, done, refund, cyc);
      end
      if ((done | refund) != 2'b00) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event: done=%b refund=%b at cycle %0d, required none",
                   done, refund, cyc);
        end else begin
          e = q.pop_front();
          if (done !== e.done || refund !== e.refund || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL event: done=%b refund=%b cycle %0d, required done=%b refund=%b cycle %0d",
                     done, refund, cyc, e.done, e.refund, e.cyc);
          end
        end
      end
    end
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    req = 2'b00;
    cup_ok = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({busy, gnt, cup_drop, pour, done, refund} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b gnt=%b cup=%b pour=%b done=%b refund=%b, required all 0",
               busy, gnt, cup_drop, pour, done, refund);
    end
    RST = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_single();
    int base = cyc;
    logic e_cup, e_pour, e_busy;
    logic [1:0] e_gnt;
    expect_ev(2'b01, 2'b00, base + 13);
    pulse_req(2'b01);
    for (int k = 1; k <= 14; k++) begin
      e_cup  = (k >= 1 && k <= 4);
      e_pour = (k >= 5 && k <= 12);
      e_busy = (k <= 13);
      e_gnt  = e_busy ? 2'b01 : 2'b00;
      vectors++;
      if ({cup_drop, pour, gnt, busy} !== {e_cup, e_pour, e_gnt, e_busy}) begin
        miscompares++;
        $display("FAIL single_cycle%0d: cup=%b pour=%b gnt=%b busy=%b, required cup=%b pour=%b gnt=%b busy=%b",
                 k, cup_drop, pour, gnt, busy, e_cup, e_pour, e_gnt, e_busy);
      end
      tick();
    end
    wait_drain(20, "single");
  endtask

  task automatic test_both();
    int base;
    apply_reset();
    base = cyc;
    expect_ev(2'b01, 2'b00, base + 13);
    expect_ev(2'b10, 2'b00, base + 27);
    pulse_req(2'b11);
    repeat (13) tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL both_gap: busy=%b in cycle %0d, required 0", busy, cyc - base);
    end
    tick();
    vectors++;
    if (cup_drop !== 1'b1 || gnt !== 2'b10) begin
      miscompares++;
      $display("FAIL both_second_start: cup=%b gnt=%b, required cup=1 gnt=10", cup_drop, gnt);
    end
    wait_drain(40, "both");
  endtask

  task automatic test_fault();
    int base = cyc;
    expect_ev(2'b00, 2'b01, base + 5);
    pulse_req(2'b01);
    for (int k = 1; k <= 7; k++) begin
      vectors++;
      if (pour !== 1'b0 || cup_drop !== (k <= 4)) begin
        miscompares++;
        $display("FAIL fault_cycle%0d: cup=%b pour=%b, required cup=%b pour=0",
                 k, cup_drop, pour, (k <= 4));
      end
      if (k == 6) begin
        vectors++;
        if (busy !== 1'b0 || gnt !== 2'b00) begin
          miscompares++;
          $display("FAIL fault_idle: busy=%b gnt=%b, required busy=0 gnt=00", busy, gnt);
        end
      end
      cup_ok = (k == 4) ? 1'b0 : 1'b1;
      tick();
    end
    cup_ok = 1'b1;
    wait_drain(20, "fault");
  endtask

  task automatic test_queue();
    int base = cyc;
    expect_ev(2'b01, 2'b00, base + 13);
    expect_ev(2'b01, 2'b00, base + 27);
    pulse_req(2'b01);
    repeat (3) begin
      tick();
      tick();
      pulse_req(2'b01);
    end
    wait_drain(60, "queue");
    repeat (30) tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL queue_extra: busy=%b after second sequence, required 0", busy);
    end
  endtask

  task automatic test_rst_abort();
    int base = cyc;
    logic seen_busy = 1'b0;
    pulse_req(2'b01);
    tick();
    tick();
    pulse_req(2'b10);
    repeat (3) tick();
    vectors++;
    if (pour !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre: pour=%b at cycle %0d, required 1", pour, cyc - base);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    vectors++;
    if ({busy, gnt, cup_drop, pour, done, refund} !== 10'b0) begin
      miscompares++;
      $display("FAIL abort_outputs: busy=%b gnt=%b cup=%b pour=%b done=%b refund=%b, required all 0",
               busy, gnt, cup_drop, pour, done, refund);
    end
    repeat (20) begin
      tick();
      if (busy) seen_busy = 1'b1;
    end
    vectors++;
    if (seen_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_pending: busy seen=%b after reset, required 0", seen_busy);
    end
    base = cyc;
    expect_ev(2'b10, 2'b00, base + 13);
    pulse_req(2'b10);
    wait_drain(30, "abort_fresh");
  endtask

  task automatic test_alternate();
    int base = cyc;
    expect_ev(2'b01, 2'b00, base + 13);
    expect_ev(2'b10, 2'b00, base + 27);
    expect_ev(2'b01, 2'b00, base + 41);
    expect_ev(2'b10, 2'b00, base + 55);
    expect_ev(2'b01, 2'b00, base + 69);
    pulse_req(2'b11);
    repeat (12) tick();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (done === 2'b00) begin
        miscompares++;
        $display("FAIL alt_repulse%0d: done=%b, required nonzero", i, done);
      end
      pulse_req(2'b11);
      repeat (13) tick();
    end
    wait_drain(100, "alternate");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_both();
    test_fault();
    test_queue();
    test_rst_abort();
    test_alternate();
    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
